// File: rtl/ser_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-counter width: enough bits to index WIDTH positions, never zero.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/par_serializer_mux_n_to_1.sv
// WIDTH:1 bit select feeding the serial output register; idles when disabled.
module mux_n_to_1
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter logic        IDLE_BIT = 1'b0,
  localparam int unsigned CW      = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    sel,
  input  logic             en,
  output logic             out
);

  assign out = en ? data[sel] : IDLE_BIT;

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial converter: valid/ready word intake, one-entry hold buffer,
// one bit per enabled clock with framing and underrun flags.
module par_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             underrun
);

  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0] hreg_q, hreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic             ur_pend_q, ur_pend_d;

  logic             accept;
  logic             shifting;
  logic [CW-1:0]    sel;
  logic             mux_out;

  assign din_ready = ~hold_full_q;
  assign accept    = din_valid & ~hold_full_q;
  assign shifting  = (state_q == ST_SHIFT) & en;
  assign sel       = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

  mux_n_to_1 #(
    .WIDTH    (WIDTH),
    .IDLE_BIT (IDLE_BIT)
  ) u_mux (
    .data (wreg_q),
    .sel  (sel),
    .en   (shifting),
    .out  (mux_out)
  );

  // Next-state and output-register inputs.
  always_comb begin
    state_d       = state_q;
    wreg_d        = wreg_q;
    hreg_d        = hreg_q;
    cnt_d         = cnt_q;
    hold_full_d   = hold_full_q;
    sout_d        = mux_out;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = ur_pend_q;
    ur_pend_d     = 1'b0;

    if (state_q == ST_IDLE) begin
      // Hold is always empty here, so a new word goes straight to wreg.
      if (accept) begin
        wreg_d  = din;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
    end else begin
      if (en) begin
        sout_valid_d  = 1'b1;
        frame_start_d = (cnt_q == '0);
      end
      if (en && (cnt_q == LAST)) begin
        cnt_d = '0;
        if (hold_full_q) begin
          wreg_d      = hreg_q;
          hold_full_d = 1'b0;
          if (accept) begin
            hreg_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (accept) begin
          wreg_d = din;
        end else begin
          state_d   = ST_IDLE;
          ur_pend_d = 1'b1;
        end
      end else begin
        if (en) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (accept) begin
          hreg_d      = din;
          hold_full_d = 1'b1;
        end
      end
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wreg_q        <= '0;
      hreg_q        <= '0;
      cnt_q         <= '0;
      hold_full_q   <= 1'b0;
      sout_q        <= IDLE_BIT;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ur_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wreg_q        <= wreg_d;
      hreg_q        <= hreg_d;
      cnt_q         <= cnt_d;
      hold_full_q   <= hold_full_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ur_pend_q     <= ur_pend_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_par_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; monitors
// pop expected {frame_start, bit} pairs whenever sout_valid is high.
module tb_par_serializer;

  logic       clk = 1'b0;
  logic       rst, en, din_valid;
  logic [3:0] din;

  logic rdy0, sout0, sv0, fs0, ur0;
  logic rdy1, sout1, sv1, fs1, ur1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int         runs[$];
  int         run    = 0;
  int         ur_cnt = 0;
  logic       ur_prev0 = 1'b0;
  logic       mon_on   = 1'b0;
  logic [1:0] e0, e1;
  int         waited;

  always #5 clk = ~clk;

  par_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .sout(sout0), .sout_valid(sv0),
    .frame_start(fs0), .underrun(ur0)
  );

  par_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sout(sout1), .sout_valid(sv1),
    .frame_start(fs1), .underrun(ur1)
  );

  task automatic cmp(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int j = 0; j < 4; j++) begin
      q0.push_back({(j == 0), w[j]});
      q1.push_back({(j == 0), w[3-j]});
    end
  endtask

  // Offer a word; returns on the negedge after the accepting edge.
  task automatic send(input logic [3:0] w, output int wt);
    wt        = 0;
    din       = w;
    din_valid = 1'b1;
    while (!rdy0 && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (!rdy0) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: din_ready stuck at 0 for word %0h", w);
      din_valid = 1'b0;
    end else begin
      push_word(w);
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_runs(input string nm, input int n, input int a, input int b);
    cmp({nm, "_runs"}, runs.size(), n);
    if (runs.size() > 0) cmp({nm, "_run0"}, runs[0], a);
    if (n > 1 && runs.size() > 1) cmp({nm, "_run1"}, runs[1], b);
    runs.delete();
  endtask

  task automatic chk_reset_outputs(input string nm);
    cmp({nm, "_sout"}, int'(sout0), 0);
    cmp({nm, "_sout_valid"}, int'(sv0), 0);
    cmp({nm, "_frame_start"}, int'(fs0), 0);
    cmp({nm, "_underrun"}, int'(ur0), 0);
    cmp({nm, "_din_ready"}, int'(rdy0), 1);
    cmp({nm, "_din_ready1"}, int'(rdy1), 1);
  endtask

  // Monitor for the LSB-first instance, including gap and underrun tracking.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sv0) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_bit0: sout=%0d with empty scoreboard", sout0);
        end else begin
          e0 = q0.pop_front();
          cmp("sout0", int'(sout0), int'(e0[0]));
          cmp("frame_start0", int'(fs0), int'(e0[1]));
        end
        run++;
      end else begin
        cmp("idle_sout0", int'({sout0, fs0}), 0);
        if (run > 0) runs.push_back(run);
        run = 0;
      end
      if (ur0) begin
        ur_cnt++;
        cmp("underrun_single", int'(ur_prev0), 0);
        cmp("underrun_in_idle", int'(sv0), 0);
      end
      ur_prev0 = ur0;
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sv1) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_bit1: sout=%0d with empty scoreboard", sout1);
        end else begin
          e1 = q1.pop_front();
          cmp("sout1", int'(sout1), int'(e1[0]));
          cmp("frame_start1", int'(fs1), int'(e1[1]));
        end
      end else begin
        cmp("idle_sout1", int'({sout1, fs1, ur1 & ~ur0}), 0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    din       = 4'hF;
    din_valid = 1'b1;
    idle(2);
    chk_reset_outputs("reset");
    din_valid = 1'b0;
    rst       = 1'b0;
    mon_on    = 1'b1;
    idle(1);

    // Single word, LSB 1,0,1,1 / MSB 1,1,0,1, then underrun.
    send(4'b1101, waited);
    idle(8);
    cmp("single_underruns", ur_cnt, 1);
    chk_runs("single", 1, 4, 0);

    // Three words streamed back to back.
    send(4'hA, waited);
    send(4'h5, waited);
    send(4'hF, waited);
    cmp("stream_ready_dropped", int'(waited > 0), 1);
    idle(10);
    cmp("stream_underruns", ur_cnt, 2);
    chk_runs("stream", 1, 12, 0);

    // Pause three cycles after bit 1.
    send(4'b0110, waited);
    idle(2);
    en = 1'b0;
    idle(3);
    cmp("pause_no_underrun", ur_cnt, 2);
    en = 1'b1;
    idle(8);
    cmp("pause_underruns", ur_cnt, 3);
    chk_runs("pause", 2, 2, 2);

    // Reset mid-word with the hold buffer full.
    send(4'h9, waited);
    send(4'h3, waited);
    cmp("hold_full_ready", int'(rdy0), 0);
    rst = 1'b1;
    idle(1);
    chk_reset_outputs("midreset");
    rst = 1'b0;
    idle(1);
    q0.delete();
    q1.delete();
    runs.delete();
    send(4'hC, waited);
    idle(8);
    cmp("post_reset_underruns", ur_cnt, 4);
    chk_runs("post_reset", 1, 4, 0);

    // Second word offered exactly on the last-bit edge.
    send(4'h6, waited);
    idle(3);
    send(4'h9, waited);
    idle(10);
    cmp("lastedge_underruns", ur_cnt, 5);
    chk_runs("lastedge", 1, 8, 0);

    cmp("scoreboard0_empty", q0.size(), 0);
    cmp("scoreboard1_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
